// File: rtl/rgb_hue_pwm_engine_pkg.sv
// Shared types and constants for the RGB hue PWM engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_SWEEP   = 2'd0,
    MODE_HOLD    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  localparam int HUE_W = 9;
  localparam logic [HUE_W-1:0] HUE_LAST = 9'd359;
  localparam int SECTOR_DEG = 60;

  // Host-supplied hues beyond the last degree saturate rather than wrap.
  function automatic logic [HUE_W-1:0] clamp_hue(input logic [HUE_W-1:0] h);
    return (h > HUE_LAST) ? HUE_LAST : h;
  endfunction

endpackage

// File: rtl/rgb_hue_pwm_engine_hue_to_rgb.sv
// Hue (0..359 degrees) to full-intensity R/G/B levels via 60-degree sectors.
// Latency: purely combinational.
// Backpressure: none.
module hue_to_rgb
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic [HUE_W-1:0]    hue,
  output logic [PWM_BITS-1:0] r_o,
  output logic [PWM_BITS-1:0] g_o,
  output logic [PWM_BITS-1:0] b_o
);

  // f*MAX stays below 60*2^PWM_BITS, so PWM_BITS+6 bits suffice; one spare.
  localparam int MW = PWM_BITS + 7;
  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [HUE_W-1:0]    sector_w;
  logic [HUE_W-1:0]    frac_w;
  logic [MW-1:0]       up_w;
  logic [MW-1:0]       dn_w;
  logic [PWM_BITS-1:0] up;
  logic [PWM_BITS-1:0] dn;

  // Split hue into sector and offset, derive rising/falling ramps, pick channels.
  always_comb begin
    sector_w = hue / HUE_W'(SECTOR_DEG);
    frac_w   = hue - sector_w * HUE_W'(SECTOR_DEG);
    up_w     = (MW'(frac_w) * MW'(MAX)) / MW'(SECTOR_DEG);
    dn_w     = (MW'(HUE_W'(SECTOR_DEG) - frac_w) * MW'(MAX)) / MW'(SECTOR_DEG);
    up       = PWM_BITS'(up_w);
    dn       = PWM_BITS'(dn_w);
    r_o      = '0;
    g_o      = '0;
    b_o      = '0;
    case (sector_w)
      9'd0: begin r_o = MAX; g_o = up;  end
      9'd1: begin r_o = dn;  g_o = MAX; end
      9'd2: begin g_o = MAX; b_o = up;  end
      9'd3: begin g_o = dn;  b_o = MAX; end
      9'd4: begin r_o = up;  b_o = MAX; end
      9'd5: begin r_o = MAX; b_o = dn;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/rgb_hue_pwm_engine.sv
// RGB LED driver: hue sweep/hold/breathe with brightness scaling and PWM outputs.
// Latency: settings reach the pins at the next PWM period start (1..2^PWM_BITS cycles).
// Backpressure: none; free-running, all inputs sampled every cycle.
module rgb_hue_pwm_engine
  import rgb_pwm_pkg::*;
#(
  parameter int CLK_FREQUENCY = 12000000,
  parameter int PWM_BITS      = 8,
  parameter int STEP_BITS     = 24,
  parameter int DEFAULT_STEP  = CLK_FREQUENCY / 360
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 dir,
  input  logic [STEP_BITS-1:0] step_interval,
  input  logic                 hue_load,
  input  logic [HUE_W-1:0]     hue_in,
  input  logic [PWM_BITS-1:0]  brightness,
  output logic                 RGB_R,
  output logic                 RGB_G,
  output logic                 RGB_B,
  output logic [HUE_W-1:0]     hue_out,
  output logic                 period_start
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  // Products of two (PWM_BITS+1)-bit-range operands, kept one bit wider.
  localparam int PW = 2 * PWM_BITS + 1;

  mode_t mode_e;
  assign mode_e = mode_t'(mode);

  logic [STEP_BITS-1:0] step_cnt_q, step_cnt_d, last_cnt;
  logic                 counting, tick;
  logic [HUE_W-1:0]     hue_q, hue_d;
  logic [PWM_BITS-1:0]  level_q, level_d;
  logic                 falling_q, falling_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]  duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
  logic [PWM_BITS-1:0]  r_c, g_c, b_c;
  logic [PW-1:0]        breathe_w, r_w, g_w, b_w;
  logic [PWM_BITS-1:0]  eff;

  hue_to_rgb #(.PWM_BITS(PWM_BITS)) u_hue_to_rgb (
    .hue (hue_q),
    .r_o (r_c),
    .g_o (g_c),
    .b_o (b_c)
  );

  // Step timer: ticks every max(step_interval,1) clocks; >= catches a lowered interval.
  always_comb begin
    counting   = (mode_e == MODE_SWEEP) || (mode_e == MODE_BREATHE);
    last_cnt   = (step_interval == '0) ? '0 : step_interval - STEP_BITS'(1);
    tick       = counting && (step_cnt_q >= last_cnt);
    step_cnt_d = (counting && !tick) ? step_cnt_q + STEP_BITS'(1) : '0;
  end

  // Hue register: host load has priority over a sweep step in the same cycle.
  always_comb begin
    hue_d = hue_q;
    if (hue_load) begin
      hue_d = clamp_hue(hue_in);
    end else if (tick && (mode_e == MODE_SWEEP)) begin
      if (!dir) hue_d = (hue_q >= HUE_LAST) ? '0 : hue_q + HUE_W'(1);
      else      hue_d = (hue_q == '0) ? HUE_LAST : hue_q - HUE_W'(1);
    end
  end

  // Breathe triangle: bounces between 0 and MAX, freezing outside BREATHE.
  always_comb begin
    level_d   = level_q;
    falling_d = falling_q;
    if (tick && (mode_e == MODE_BREATHE)) begin
      if (!falling_q) begin
        if (level_q == MAX) begin
          level_d   = MAX - PWM_BITS'(1);
          falling_d = 1'b1;
        end else begin
          level_d = level_q + PWM_BITS'(1);
        end
      end else begin
        if (level_q == '0) begin
          level_d   = PWM_BITS'(1);
          falling_d = 1'b0;
        end else begin
          level_d = level_q - PWM_BITS'(1);
        end
      end
    end
  end

  // Intensity scaling; the +1 makes full scale exact and zero fully dark.
  always_comb begin
    breathe_w = PW'(brightness) * (PW'(level_q) + PW'(1));
    eff       = (mode_e == MODE_BREATHE) ? PWM_BITS'(breathe_w >> PWM_BITS) : brightness;
    r_w       = PW'(r_c) * (PW'(eff) + PW'(1));
    g_w       = PW'(g_c) * (PW'(eff) + PW'(1));
    b_w       = PW'(b_c) * (PW'(eff) + PW'(1));
  end

  // PWM counter and shadow duties; duties only move on the last count of a period.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    duty_r_d  = duty_r_q;
    duty_g_d  = duty_g_q;
    duty_b_d  = duty_b_q;
    if (pwm_cnt_q == MAX) begin
      duty_r_d = PWM_BITS'(r_w >> PWM_BITS);
      duty_g_d = PWM_BITS'(g_w >> PWM_BITS);
      duty_b_d = PWM_BITS'(b_w >> PWM_BITS);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
      hue_q      <= '0;
      level_q    <= '0;
      falling_q  <= 1'b0;
      pwm_cnt_q  <= '0;
      duty_r_q   <= '0;
      duty_g_q   <= '0;
      duty_b_q   <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      hue_q      <= hue_d;
      level_q    <= level_d;
      falling_q  <= falling_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_r_q   <= duty_r_d;
      duty_g_q   <= duty_g_d;
      duty_b_q   <= duty_b_d;
    end
  end

  // OFF gates the pins immediately while the duties keep tracking.
  always_comb begin
    RGB_R        = (mode_e != MODE_OFF) && (pwm_cnt_q < duty_r_q);
    RGB_G        = (mode_e != MODE_OFF) && (pwm_cnt_q < duty_g_q);
    RGB_B        = (mode_e != MODE_OFF) && (pwm_cnt_q < duty_b_q);
    hue_out      = hue_q;
    period_start = (pwm_cnt_q == '0);
  end

endmodule
